// File: rtl/drop_controller.sv
// Move sequencer for the 4x4 Connect-4 core.
// Applies gravity, owns the board, alternates turns, freezes on a result.
module drop_controller #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int COL_W      = 2,
  parameter int STATUS_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 new_game,
  input  logic                 move_valid,
  input  logic [COL_W-1:0]     move_col,
  output logic                 move_ready,
  input  logic [1:0]           game_status,
  output logic [ROWS*COLS-1:0] game_board,
  output logic [ROWS*COLS-1:0] player_cells,
  output logic                 current_player,
  output logic                 move_done,
  output logic                 move_reject,
  output logic                 game_over
);

  localparam int N  = ROWS * COLS;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int WW = (STATUS_LAT > 1) ? $clog2(STATUS_LAT) : 1;
  localparam logic [WW-1:0] WAIT_LOAD = WW'(STATUS_LAT - 1);
  localparam logic [RW-1:0] ROW_TOP   = RW'(ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_WAIT,
    S_CHECK,
    S_OVER
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [N-1:0]    r_board;
  logic [N-1:0]    r_cells;
  logic            r_player;
  logic            r_player_lat;
  logic            r_over;
  logic            r_reject;
  logic [COL_W-1:0] r_col;
  logic [RW-1:0]   r_row;
  logic [WW-1:0]   r_wait;

  logic            w_accept;
  logic            w_col_bad;
  logic [IW-1:0]   w_idx;
  logic            w_occ;
  logic            w_row_top;
  logic            w_wait_done;
  logic            w_end;

  assign w_accept    = move_valid && move_ready && !new_game;
  assign w_col_bad   = (int'(move_col) >= COLS);
  assign w_idx       = IW'(int'(r_row) * COLS + int'(r_col));
  assign w_occ       = r_board[w_idx];
  assign w_row_top   = (r_row == ROW_TOP);
  assign w_wait_done = (r_wait == '0);
  assign w_end       = (game_status != 2'b00) || (&r_board);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; new_game overrides every state
  always_comb begin
    w_next = r_state;
    if (new_game) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && !w_col_bad) w_next = S_SCAN;
        end
        S_SCAN: begin
          if (!w_occ)         w_next = S_WAIT;
          else if (w_row_top) w_next = S_IDLE;
        end
        S_WAIT: begin
          if (w_wait_done) w_next = S_CHECK;
        end
        S_CHECK: begin
          w_next = w_end ? S_OVER : S_IDLE;
        end
        S_OVER:  w_next = S_OVER;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Board, turn, scan pointer and result flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_board      <= '0;
      r_cells      <= '0;
      r_player     <= 1'b0;
      r_player_lat <= 1'b0;
      r_over       <= 1'b0;
      r_reject     <= 1'b0;
      r_col        <= '0;
      r_row        <= '0;
      r_wait       <= '0;
    end else begin
      r_reject <= 1'b0;
      if (new_game) begin
        r_board  <= '0;
        r_cells  <= '0;
        r_player <= 1'b0;
        r_over   <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              if (w_col_bad) begin
                r_reject <= 1'b1;
              end else begin
                r_col        <= move_col;
                r_player_lat <= r_player;
                r_row        <= '0;
              end
            end
          end
          S_SCAN: begin
            if (!w_occ) begin
              r_board[w_idx] <= 1'b1;
              r_cells[w_idx] <= r_player_lat;
              r_wait         <= WAIT_LOAD;
            end else if (w_row_top) begin
              r_reject <= 1'b1;
            end else begin
              r_row <= r_row + 1'b1;
            end
          end
          S_WAIT: begin
            if (!w_wait_done) r_wait <= r_wait - 1'b1;
          end
          S_CHECK: begin
            if (w_end) r_over   <= 1'b1;
            else       r_player <= ~r_player;
          end
          default: ;
        endcase
      end
    end
  end

  // Moore outputs
  always_comb begin
    move_ready = (r_state == S_IDLE);
    move_done  = (r_state == S_CHECK);
  end

  assign game_board     = r_board;
  assign player_cells   = r_cells;
  assign current_player = r_player;
  assign move_reject    = r_reject;
  assign game_over      = r_over;

endmodule

// File: tb/tb_drop_controller.sv
// Scoreboard bench for drop_controller.
// Directed drops; a monitor checks every done/reject pulse.
module tb_drop_controller;

  localparam int ROWS       = 4;
  localparam int COLS       = 4;
  localparam int COL_W      = 2;
  localparam int STATUS_LAT = 1;
  localparam int N          = ROWS * COLS;

  logic             clk = 1'b0;
  logic             rst;
  logic             new_game;
  logic             move_valid;
  logic [COL_W-1:0] move_col;
  logic             move_ready;
  logic [1:0]       game_status;
  logic [N-1:0]     game_board;
  logic [N-1:0]     player_cells;
  logic             current_player;
  logic             move_done;
  logic             move_reject;
  logic             game_over;

  drop_controller #(
    .ROWS(ROWS), .COLS(COLS), .COL_W(COL_W), .STATUS_LAT(STATUS_LAT)
  ) dut (
    .clk(clk), .rst(rst), .new_game(new_game),
    .move_valid(move_valid), .move_col(move_col),
    .move_ready(move_ready), .game_status(game_status),
    .game_board(game_board), .player_cells(player_cells),
    .current_player(current_player), .move_done(move_done),
    .move_reject(move_reject), .game_over(game_over)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit           rej;
    logic [N-1:0] board;
    logic [N-1:0] cells;
    logic         player;
    int           acc;
    int           lat;
  } exp_t;

  exp_t q[$];
  int pass_cnt = 0;
  int total    = 0;

  // bench-side game model
  int           h[COLS];
  logic [N-1:0] mb;
  logic [N-1:0] mc;
  logic         mp;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic model_clear();
    for (int i = 0; i < COLS; i++) h[i] = 0;
    mb = '0;
    mc = '0;
    mp = 1'b0;
  endtask

  // monitor: pops one expectation per response pulse
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (move_done || move_reject)) begin
      chk("one_pulse", 32'(move_done && move_reject), 0);
      if (q.size() == 0) begin
        chk("unexpected_resp", {30'd0, move_done, move_reject}, 0);
      end else begin
        e = q.pop_front();
        chk("resp_kind", 32'(move_reject), 32'(e.rej));
        chk("resp_board", 32'(game_board), 32'(e.board));
        chk("resp_cells", 32'(player_cells), 32'(e.cells));
        chk("resp_player", 32'(current_player), 32'(e.player));
        chk("resp_latency", cyc - e.acc, e.lat);
      end
    end
  end

  task automatic drop(input int col);
    exp_t e;
    int t;
    int idx;
    @(negedge clk);
    t = 0;
    while (!move_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!move_ready) chk("ready_timeout", 0, 1);
    move_valid = 1'b1;
    move_col   = COL_W'(col);
    @(posedge clk);
    #1;
    move_valid = 1'b0;
    e.acc    = cyc;
    e.player = mp;
    e.rej    = (h[col] >= ROWS);
    if (e.rej) begin
      e.lat = ROWS;
    end else begin
      idx     = h[col] * COLS + col;
      mb[idx] = 1'b1;
      mc[idx] = mp;
      h[col]++;
      e.lat = h[col] + STATUS_LAT;
    end
    e.board = mb;
    e.cells = mc;
    q.push_back(e);
    t = 0;
    while (q.size() != 0 && t < 30) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) begin
      chk("resp_timeout", 0, 1);
      q.delete();
    end
    if (!e.rej && !(game_status != 2'b00 || (&mb))) mp = ~mp;
    @(negedge clk);
  endtask

  task automatic do_new_game();
    @(negedge clk);
    new_game = 1'b1;
    @(posedge clk);
    #1;
    new_game = 1'b0;
    model_clear();
    chk("ng_board", 32'(game_board), 0);
    chk("ng_over", 32'(game_over), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    bit seen;
    rst         = 1'b1;
    new_game    = 1'b0;
    move_valid  = 1'b0;
    move_col    = '0;
    game_status = 2'b00;
    model_clear();
    #2;
    chk("rst_board", 32'(game_board), 0);
    chk("rst_cells", 32'(player_cells), 0);
    chk("rst_player", 32'(current_player), 0);
    chk("rst_over", 32'(game_over), 0);
    chk("rst_done_rej", {30'd0, move_done, move_reject}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(move_ready), 1);

    // 1,2: first two drops into col 0
    drop(0);
    chk("t1_board", 32'(game_board), 32'h0001);
    chk("t1_cells", 32'(player_cells), 32'h0000);
    chk("t1_player", 32'(current_player), 1);
    drop(0);
    chk("t2_board", 32'(game_board), 32'h0011);
    chk("t2_cells", 32'(player_cells), 32'h0010);
    chk("t2_player", 32'(current_player), 0);

    // 3: fill col 2, fifth drop rejected
    do_new_game();
    for (int i = 0; i < 5; i++) drop(2);
    chk("t3_board", 32'(game_board), 32'h4444);
    chk("t3_cells", 32'(player_cells), 32'h4040);
    chk("t3_player", 32'(current_player), 0);

    // new_game beats a same-edge request
    @(negedge clk);
    move_valid = 1'b1;
    move_col   = 2'd1;
    new_game   = 1'b1;
    @(posedge clk);
    #1;
    move_valid = 1'b0;
    new_game   = 1'b0;
    model_clear();
    chk("ng_vs_req_ready", 32'(move_ready), 1);
    chk("ng_vs_req_board", 32'(game_board), 0);
    repeat (5) @(negedge clk);

    // 4: P1 win detected after last P1 placement
    do_new_game();
    drop(1); drop(1); drop(2); drop(2); drop(0); drop(0);
    game_status = 2'b01;
    drop(3);
    chk("t4_board", 32'(game_board), 32'h007F);
    chk("t4_cells", 32'(player_cells), 32'h0070);
    chk("t4_over", 32'(game_over), 1);
    chk("t4_ready", 32'(move_ready), 0);
    chk("t4_player", 32'(current_player), 0);
    game_status = 2'b00;
    @(negedge clk);
    move_valid = 1'b1;
    move_col   = 2'd3;
    repeat (4) @(negedge clk);
    move_valid = 1'b0;
    chk("t4_ignored_board", 32'(game_board), 32'h007F);
    chk("t4_still_over", 32'(game_over), 1);

    // 5: full board with detector at 00
    do_new_game();
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++) drop(c);
    chk("t5_board", 32'(game_board), 32'hFFFF);
    chk("t5_cells", 32'(player_cells), 32'hF0F0);
    chk("t5_over", 32'(game_over), 1);
    chk("t5_player", 32'(current_player), 1);
    chk("t5_ready", 32'(move_ready), 0);

    // 6a: asynchronous reset during SCAN
    do_new_game();
    drop(0);
    chk("t6_pre_board", 32'(game_board), 32'h0001);
    @(negedge clk);
    move_valid = 1'b1;
    move_col   = 2'd1;
    @(posedge clk);
    #1;
    move_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("t6_rst_board", 32'(game_board), 0);
    chk("t6_rst_cells", 32'(player_cells), 0);
    chk("t6_rst_player", 32'(current_player), 0);
    chk("t6_rst_flags", {29'd0, game_over, move_done, move_reject}, 0);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    @(negedge clk);
    chk("t6_rst_ready", 32'(move_ready), 1);

    // 6b: new_game during WAIT drops the move silently
    move_valid = 1'b1;
    move_col   = 2'd3;
    @(posedge clk);
    #1;
    move_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("t6_wait_board", 32'(game_board), 32'h0008);
    @(negedge clk);
    new_game = 1'b1;
    @(posedge clk);
    #1;
    new_game = 1'b0;
    chk("t6_ng_board", 32'(game_board), 0);
    chk("t6_ng_ready", 32'(move_ready), 1);
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (move_done || move_reject) seen = 1'b1;
    end
    chk("t6_no_done", 32'(seen), 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
